// File: rtl/sysid_check_ctrl.sv
// Avalon-MM sequencer that reads the sysid ID and timestamp words, compares
// them against expected constants and reports pass/fail/timeout once per start.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h64C5726D,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    CHECK,
    FIN
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAT_RELOAD    = 2'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic [15:0] wdog_q, wdog_d;
  logic [1:0]  lat_q, lat_d;

  logic [15:0] wdog_inc;
  logic        expired;
  logic        capture;
  logic        capture_ts;
  logic        abort;

  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    avm_address_d = avm_address_q;
    avm_read_d    = avm_read_q;
    wdog_d        = wdog_q;
    lat_d         = lat_q;
    capture       = 1'b0;
    capture_ts    = 1'b0;
    abort         = 1'b0;

    // The watchdog value including the current cycle; a capture on the
    // cycle it expires still wins, so expiry is only acted on otherwise.
    wdog_inc = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
    expired  = (wdog_inc >= TIMEOUT_LIMIT);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RD_ID;
          busy_d        = 1'b1;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_d     = 1'b0;
          id_value_d    = '0;
          ts_value_d    = '0;
          wdog_d        = '0;
        end
      end
      RD_ID, RD_TS: begin
        wdog_d     = wdog_inc;
        capture_ts = (state_q == RD_TS);
        if (!avm_waitrequest && READ_LATENCY == 0) begin
          capture = 1'b1;
        end else if (!avm_waitrequest && !expired) begin
          state_d    = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          avm_read_d = 1'b0;
          lat_d      = LAT_RELOAD;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      LAT_ID, LAT_TS: begin
        wdog_d     = wdog_inc;
        capture_ts = (state_q == LAT_TS);
        if (lat_q == 2'd0) begin
          capture = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      CHECK: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TS);
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Word 0 hands over to the word-1 read with a fresh watchdog.
    if (capture) begin
      if (!capture_ts) begin
        id_value_d    = avm_readdata;
        state_d       = RD_TS;
        avm_read_d    = 1'b1;
        avm_address_d = 1'b1;
        wdog_d        = '0;
      end else begin
        ts_value_d = avm_readdata;
        state_d    = CHECK;
        avm_read_d = 1'b0;
      end
    end

    if (abort) begin
      state_d    = FIN;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      avm_read_d = 1'b0;
      timeout_d  = 1'b1;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      avm_address_q <= 1'b0;
      avm_read_q    <= 1'b0;
      wdog_q        <= '0;
      lat_q         <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      avm_address_q <= avm_address_d;
      avm_read_q    <= avm_read_d;
      wdog_q        <= wdog_d;
      lat_q         <= lat_d;
    end
  end

endmodule
